// File: rtl/float_to_fixed.sv
// Iterative IEEE-754 single to signed 32-bit fixed-point converter (value * 2^F).
// Optional round-half-away-from-zero on right shifts: define FTOF_ROUND_NEAREST_EN.
module float_to_fixed (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] float_in,
    input  logic [7:0]  exp_in,
    input  logic        load_new,
    output logic [31:0] fixed_out,
    output logic        done,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_r, state_next_s;
    logic [31:0]        float_r;
    logic [7:0]         fbits_r;
    logic [31:0]        mag_r;
    logic [4:0]         cnt_r;
    logic               left_r, sat_r, nan_r, min_r;
`ifdef FTOF_ROUND_NEAREST_EN
    logic               guard_r;
`endif
    logic [31:0]        fixed_out_r;
    logic               done_r, busy_r, overflow_r;

    logic [7:0]         exp_fld_s;
    logic [22:0]        frac_s;
    logic               sign_s;
    logic signed [9:0]  shift_s;
    logic [9:0]         neg_shift_s;
    logic [31:0]        un_mag_s;
    logic [4:0]         un_cnt_s;
    logic               un_left_s, un_sat_s, un_nan_s, un_min_s;
    logic               round_s;
    logic [32:0]        rnd_mag_s, limit_s;
    logic [31:0]        sat_val_s, res_s;
    logic               res_ovf_s;

    assign exp_fld_s   = float_r[30:23];
    assign frac_s      = float_r[22:0];
    assign sign_s      = float_r[31];
    assign shift_s     = {2'b00, exp_fld_s} + {2'b00, fbits_r} - 10'd150;
    assign neg_shift_s = 10'd0 - shift_s;

    // Classify the registered float and derive the shift direction and count.
    always_comb begin
        un_mag_s  = {8'd0, 1'b1, frac_s};
        un_cnt_s  = 5'd0;
        un_left_s = 1'b0;
        un_sat_s  = 1'b0;
        un_nan_s  = 1'b0;
        un_min_s  = 1'b0;
        if (exp_fld_s == 8'd0) begin
            un_mag_s = 32'd0;
        end else if (exp_fld_s == 8'hFF) begin
            un_mag_s = 32'd0;
            if (frac_s == 23'd0) begin
                un_sat_s = 1'b1;
            end else begin
                un_nan_s = 1'b1;
            end
        end else if (shift_s >= 10'sd8) begin
            un_mag_s = 32'd0;
            // -2^31 is the one magnitude at s=8 that is still representable.
            if (sign_s && (shift_s == 10'sd8) && (frac_s == 23'd0)) begin
                un_min_s = 1'b1;
            end else begin
                un_sat_s = 1'b1;
            end
        end else if (shift_s >= 10'sd0) begin
            un_left_s = 1'b1;
            un_cnt_s  = {2'b00, shift_s[2:0]};
        end else if (neg_shift_s > 10'd25) begin
            un_cnt_s = 5'd25;
        end else begin
            un_cnt_s = neg_shift_s[4:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_new) begin
                    state_next_s = UNPACK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            UNPACK: begin
                if (un_cnt_s == 5'd0) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_r == 5'd1) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Apply rounding, saturation and sign to the final magnitude.
    always_comb begin
`ifdef FTOF_ROUND_NEAREST_EN
        round_s = guard_r;
`else
        round_s = 1'b0;
`endif
        rnd_mag_s = {1'b0, mag_r} + {32'd0, round_s};
        limit_s   = sign_s ? 33'h0_8000_0000 : 33'h0_7FFF_FFFF;
        sat_val_s = sign_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        res_s     = 32'd0;
        res_ovf_s = 1'b0;
        if (nan_r) begin
            res_ovf_s = 1'b1;
        end else if (sat_r || (rnd_mag_s > limit_s)) begin
            res_s     = sat_val_s;
            res_ovf_s = 1'b1;
        end else if (min_r) begin
            res_s = 32'h8000_0000;
        end else if (sign_s) begin
            res_s = 32'd0 - rnd_mag_s[31:0];
        end else begin
            res_s = rnd_mag_s[31:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture and the one-bit-per-cycle shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            float_r <= 32'd0;
            fbits_r <= 8'd0;
            mag_r   <= 32'd0;
            cnt_r   <= 5'd0;
            left_r  <= 1'b0;
            sat_r   <= 1'b0;
            nan_r   <= 1'b0;
            min_r   <= 1'b0;
`ifdef FTOF_ROUND_NEAREST_EN
            guard_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (load_new) begin
                        float_r <= float_in;
                        fbits_r <= exp_in;
                    end
                end
                UNPACK: begin
                    mag_r   <= un_mag_s;
                    cnt_r   <= un_cnt_s;
                    left_r  <= un_left_s;
                    sat_r   <= un_sat_s;
                    nan_r   <= un_nan_s;
                    min_r   <= un_min_s;
`ifdef FTOF_ROUND_NEAREST_EN
                    guard_r <= 1'b0;
`endif
                end
                SHIFT: begin
                    cnt_r <= cnt_r - 5'd1;
                    if (left_r) begin
                        mag_r <= {mag_r[30:0], 1'b0};
                    end else begin
                        mag_r <= {1'b0, mag_r[31:1]};
`ifdef FTOF_ROUND_NEAREST_EN
                        guard_r <= mag_r[0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; busy stays high through the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fixed_out_r <= 32'd0;
            overflow_r  <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            done_r <= (state_r == DONE);
            busy_r <= (state_next_s != IDLE) || (state_r == DONE);
            if (state_r == DONE) begin
                fixed_out_r <= res_s;
                overflow_r  <= res_ovf_s;
            end
        end
    end

    assign fixed_out = fixed_out_r;
    assign overflow  = overflow_r;
    assign done      = done_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed scoreboard bench for float_to_fixed: values, overflow, latency, busy and reset.
module tb_float_to_fixed;

    logic        clk;
    logic        rst_n;
    logic [31:0] float_in;
    logic [7:0]  exp_in;
    logic        load_new;
    logic [31:0] fixed_out;
    logic        done;
    logic        busy;
    logic        overflow;

    typedef struct {
        logic [31:0] val;
        logic        ovf;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t0       = 0;

    float_to_fixed dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .float_in  (float_in),
        .exp_in    (exp_in),
        .load_new  (load_new),
        .fixed_out (fixed_out),
        .done      (done),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic start(input logic [31:0] f, input logic [7:0] fb,
                         input logic [31:0] v, input logic o, input int n);
        exp_t e;
        e.val = v;
        e.ovf = o;
        e.n   = n;
        @(negedge clk);
        float_in = f;
        exp_in   = fb;
        load_new = 1'b1;
        sb.push_back(e);
        t0 = cyc + 1;
        @(negedge clk);
        load_new = 1'b0;
    endtask

    task automatic finish_conv(input string tag);
        exp_t e;
        int   k;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        if (!done) begin
            check({tag, "_timeout"}, {31'd0, done}, 32'd1);
        end else begin
            check({tag, "_value"}, fixed_out, e.val);
            check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
            check({tag, "_latency"}, cyc - t0, 2 + e.n);
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
            check({tag, "_pulse"}, {31'd0, done}, 32'd0);
        end
    endtask

    task automatic conv(input string tag, input logic [31:0] f, input logic [7:0] fb,
                        input logic [31:0] v, input logic o, input int n);
        start(f, fb, v, o, n);
        finish_conv(tag);
    endtask

    initial begin
        logic seen_done;
        rst_n    = 1'b0;
        float_in = 32'd0;
        exp_in   = 8'd0;
        load_new = 1'b0;
        #1;
        check("rst_fixed", fixed_out, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        conv("one_q16",    32'h3F80_0000, 8'd16, 32'h0001_0000, 1'b0, 7);
        conv("m2p5_q16",   32'hC020_0000, 8'd16, 32'hFFFD_8000, 1'b0, 6);
        conv("inf_f0",     32'h7F80_0000, 8'd0,  32'h7FFF_FFFF, 1'b1, 0);
        conv("p2e31_f0",   32'h4F00_0000, 8'd0,  32'h7FFF_FFFF, 1'b1, 0);
        conv("m2e31_f0",   32'hCF00_0000, 8'd0,  32'h8000_0000, 1'b0, 0);
        conv("nan_f0",     32'h7FC0_0000, 8'd0,  32'h0000_0000, 1'b1, 0);
        conv("denorm_q16", 32'h0000_0001, 8'd16, 32'h0000_0000, 1'b0, 0);
        conv("ninf_f0",    32'hFF80_0000, 8'd0,  32'h8000_0000, 1'b1, 0);
        conv("one_f30",    32'h3F80_0000, 8'd30, 32'h4000_0000, 1'b0, 7);
        conv("one_f23",    32'h3F80_0000, 8'd23, 32'h0080_0000, 1'b0, 0);
        conv("mone_f31",   32'hBF80_0000, 8'd31, 32'h8000_0000, 1'b0, 0);
        conv("p32k_q16",   32'h4700_0000, 8'd16, 32'h7FFF_FFFF, 1'b1, 0);
        conv("one_f255",   32'h3F80_0000, 8'd255, 32'h7FFF_FFFF, 1'b1, 0);
        conv("one_f0",     32'h3F80_0000, 8'd0,  32'h0000_0001, 1'b0, 23);
        conv("tiny_f0",    32'h0080_0000, 8'd0,  32'h0000_0000, 1'b0, 25);
`ifdef FTOF_ROUND_NEAREST_EN
        conv("p0p75_f0",   32'h3F40_0000, 8'd0,  32'h0000_0001, 1'b0, 24);
        conv("p1p5_f0",    32'h3FC0_0000, 8'd0,  32'h0000_0002, 1'b0, 23);
        conv("m1p5_f0",    32'hBFC0_0000, 8'd0,  32'hFFFF_FFFE, 1'b0, 23);
`else
        conv("p0p75_f0",   32'h3F40_0000, 8'd0,  32'h0000_0000, 1'b0, 24);
        conv("p1p5_f0",    32'h3FC0_0000, 8'd0,  32'h0000_0001, 1'b0, 23);
        conv("m1p5_f0",    32'hBFC0_0000, 8'd0,  32'hFFFF_FFFF, 1'b0, 23);
`endif

        // A load strobe in the middle of a conversion must be ignored.
        start(32'h3F80_0000, 8'd16, 32'h0001_0000, 1'b0, 7);
        @(negedge clk);
        @(negedge clk);
        check("busy_mid", {31'd0, busy}, 32'd1);
        float_in = 32'h4000_0000;
        exp_in   = 8'd4;
        load_new = 1'b1;
        @(negedge clk);
        load_new = 1'b0;
        finish_conv("ignored_load");
        repeat (4) @(negedge clk);
        check("no_extra_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of shifting discards the conversion.
        start(32'hC020_0000, 8'd16, 32'hFFFD_8000, 1'b0, 6);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_fixed", fixed_out, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        void'(sb.pop_front());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("midrst_no_done", {31'd0, seen_done}, 32'd0);
        conv("recover_one", 32'h3F80_0000, 8'd16, 32'h0001_0000, 1'b0, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
